// File: rtl/opendap_ap_pkg.sv
// ============================================================================
// opendap_ap_pkg : shared constants for the SW-DP AP access scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package opendap_ap_pkg;

  localparam int W_APSEL_DEF  = 8;
  localparam int W_APBANK_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;
  localparam state_t DRAIN  = 2'd3;

  // paddr layout: {apsel, apbanksel, A[3:2], 2'b00}
  localparam int PADDR_ADDR_LSB = 2;
  localparam int PADDR_BANK_LSB = 4;

endpackage

`default_nettype wire

// File: rtl/opendap_ap_access_sched.sv
// ============================================================================
// opendap_ap_access_sched : serialises DP-requested AP accesses onto an APB bus
// Rev 1.0
// ============================================================================
`default_nettype none

module opendap_ap_access_sched
  import opendap_ap_pkg::*;
#(
  parameter int W_APSEL  = W_APSEL_DEF,
  parameter int W_APBANK = W_APBANK_DEF
) (
  input  logic                                   swclk,
  input  logic                                   rst,
  input  logic                                   req_en,
  input  logic                                   req_r_nw,
  input  logic [1:0]                             req_addr,
  input  logic [31:0]                            req_wdata,
  input  logic [W_APSEL-1:0]                     select_apsel,
  input  logic [W_APBANK-1:0]                    select_apbanksel,
  input  logic                                   abort,
  output logic                                   ap_rdy,
  output logic [31:0]                            rdbuff,
  output logic                                   set_stickyerr,
  output logic                                   req_dropped,
  output logic [W_APSEL+W_APBANK+PADDR_BANK_LSB-1:0] paddr,
  output logic                                   psel,
  output logic                                   penable,
  output logic                                   pwrite,
  output logic [31:0]                            pwdata,
  input  logic [31:0]                            prdata,
  input  logic                                   pready,
  input  logic                                   pslverr
);

  localparam int W_PADDR = W_APSEL + W_APBANK + PADDR_BANK_LSB;

  state_t             r_state;
  logic               r_ap_rdy;
  logic [31:0]        r_rdbuff;
  logic               r_stickyerr;
  logic               r_dropped;
  logic [W_PADDR-1:0] r_paddr;
  logic               r_psel;
  logic               r_penable;
  logic               r_pwrite;
  logic [31:0]        r_pwdata;

  always_ff @(posedge swclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ap_rdy    <= 1'b1;
      r_rdbuff    <= '0;
      r_stickyerr <= 1'b0;
      r_dropped   <= 1'b0;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
    end else begin
      r_stickyerr <= 1'b0;
      r_dropped   <= req_en && !r_ap_rdy;
      case (r_state)
        IDLE: begin
          if (req_en) begin
            r_paddr  <= {select_apsel, select_apbanksel, req_addr, 2'b00};
            r_pwrite <= ~req_r_nw;
            r_pwdata <= req_wdata;
            r_psel   <= 1'b1;
            r_ap_rdy <= 1'b0;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          // An abort here still runs the full APB handshake; only the result is dropped.
          r_penable <= 1'b1;
          r_state   <= abort ? DRAIN : ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ap_rdy  <= 1'b1;
            r_state   <= IDLE;
            if (!abort) begin
              if (pslverr)
                r_stickyerr <= 1'b1;
              else if (!r_pwrite)
                r_rdbuff <= prdata;
            end
          end else if (abort) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ap_rdy  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ap_rdy        = r_ap_rdy;
  assign rdbuff        = r_rdbuff;
  assign set_stickyerr = r_stickyerr;
  assign req_dropped   = r_dropped;
  assign paddr         = r_paddr;
  assign psel          = r_psel;
  assign penable       = r_penable;
  assign pwrite        = r_pwrite;
  assign pwdata        = r_pwdata;

endmodule

`default_nettype wire
